phy_tx_serializer: RTL
======================

// Module: phy_tx_serializer
// PURPOSE
//  Transmit half of the two-lane PHY link. Takes 32-bit words over a valid/ready
//  handshake, byte-stripes them over two serial lanes (serial_data_0/1), 1 bit per
//  clk_32f cycle, MSB first. Sends an initial comma training sequence after reset,
//  then the comma as idle fill. Drives the lanes the PHY receiver samples.
// PARAMETERS
//  COMMA      8'hBC  symbol used for training and idle fill
//  N_BC_INIT  4      comma slots sent per lane after reset; must be even and >=2
// PORTS
//  clk_32f        in   1   bit clock; only clock; all logic on posedge
//  reset          in   1   synchronous reset, active-high
//  data_in        in   32  word to transmit
//  valid_in       in   1   data_in valid
//  ready_out      out  1   holding register empty; transfer = valid_in & ready_out
//  serial_data_0  out  1   lane 0 serial bit (registered)
//  serial_data_1  out  1   lane 1 serial bit (registered)
//  tx_active      out  1   training done, data may be sent
//  data_frame     out  1   current frame carries a data word (not idle comma)
// BEHAVIOUR
//  Reset (sampled at posedge): serial_data_0/1=0, ready_out=1, tx_active=0,
//   data_frame=0, hold reg empty, bit_cnt=0, slot=0, state=START. Reset mid-frame
//   aborts the frame and drops any held word.
//  Framing: slot = 8 cycles (one byte per lane); frame = 2 slots = 16 cycles.
//   3-bit bit_cnt, 1-bit slot. frame_end = (bit_cnt==7 && slot==1).
//   16-bit shift reg per lane; serial_data_x = MSB flop; shift left each cycle.
//  Lane mapping per frame: slot0 lane0=data[31:24], lane1=data[23:16];
//   slot1 lane0=data[15:8], lane1=data[7:0]. Idle/training frame: COMMA in all 4.
//  FSM:
//   START : next edge loads a comma frame, bit_cnt=0, slot=0 -> INIT.
//   INIT  : comma frames only (held word kept, not sent). At frame_end, after
//           N_BC_INIT/2 frames total, go ACTIVE; the reload at that edge is already
//           an ACTIVE reload.
//   ACTIVE: at every frame_end edge, reload: hold full -> load word, clear hold,
//           data_frame=1; else load comma frame, data_frame=0. tx_active=1.
//  Handshake: ready_out = ~hold_full (registered state). Accept only when hold is
//   empty. A word is never dropped or duplicated. Frame reload and new accept
//   cannot collide: ready_out is low while hold is full. Hold clears on the reload
//   edge, so ready_out rises on the next cycle.
//  Latency: an accepted word starts on the next ACTIVE reload edge. First bit is
//   1..16 cycles after the accept edge. Sustained throughput: 1 word / 16 cycles.
//  Timing: reset released before edge E0. E0 = START load. E16 = 2nd comma frame.
//   E32 = first ACTIVE reload, tx_active=1 after E32 (N_BC_INIT=4).
//  Data bytes equal to COMMA are sent unmodified (no escaping); comma/data
//   disambiguation belongs to the receiver's link layer.
// TESTING
//  1 Reset 4 cycles, release, valid_in=0 -> both lanes repeat 1,0,1,1,1,1,0,0;
//    tx_active rises after E32; data_frame stays 0.
//  2 After tx_active, one word 32'hFF00A55A -> lane0 11111111 then 10100101,
//    lane1 00000000 then 01011010; data_frame=1 for those 16 cycles, then comma.
//  3 valid_in held high with 3 words back-to-back -> ready_out low while hold full;
//    three contiguous data frames, no gap, no loss, correct order.
//  4 Word presented at E5 (during INIT) -> accepted, ready_out=0, first data frame
//    starts at E32; frames at E0 and E16 are commas.
//  5 reset asserted at bit_cnt=3 of a data frame -> next cycle serial_data=0,
//    ready_out=1, held word discarded; comma training restarts from START.
//  6 Random valid_in gaps, 200 words -> scoreboard receive order == send order,
//    every frame boundary at a 16-cycle multiple from E0.

Source files
------------

// File: rtl/phy_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// phy_tx_serializer_if
// Word handshake between a producer and the PHY transmit serializer.
//
// Signals
//   data_in    32-bit word offered by the producer
//   valid_in   data_in holds a word the producer wants to send
//   ready_out  serializer holding register is empty; a word moves across on
//              any clock edge where valid_in and ready_out are both high
//
// Modports
//   master  producer side (drives data_in/valid_in, observes ready_out)
//   slave   serializer side (observes data_in/valid_in, drives ready_out)
// ----------------------------------------------------------------------------
interface phy_tx_serializer_if;

   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;

   modport master (
      output data_in,
      output valid_in,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out
   );

endinterface

// File: rtl/phy_tx_serializer.sv
// ----------------------------------------------------------------------------
// phy_tx_serializer
// Transmit half of the two-lane PHY link. Accepts 32-bit words over a
// valid/ready handshake and byte-stripes each word over two serial lanes,
// one bit per clk_32f cycle, MSB first. After reset a short comma training
// sequence is sent; afterwards the comma symbol is used as idle fill.
//
// Frame layout (16 cycles, two 8-cycle slots):
//   slot 0: lane 0 = word[31:24], lane 1 = word[23:16]
//   slot 1: lane 0 = word[15:8],  lane 1 = word[7:0]
//   idle / training frames carry COMMA in all four byte positions.
//
// Parameters
//   COMMA      symbol used for training and idle fill
//   N_BC_INIT  comma slots sent per lane after reset (even, >= 2)
//
// Ports
//   clk_32f        bit clock, all logic on its rising edge
//   reset          synchronous active-high reset
//   tx_if          slave side of the word handshake (data_in/valid_in/ready_out)
//   serial_data_0  lane 0 serial bit, straight from a flop
//   serial_data_1  lane 1 serial bit, straight from a flop
//   tx_active      training finished, data words may go out
//   data_frame     the frame currently on the lanes carries a data word
// ----------------------------------------------------------------------------
module phy_tx_serializer #(
   parameter logic [7:0] COMMA     = 8'hBC,
   parameter int         N_BC_INIT = 4
) (
   input  logic               clk_32f,
   input  logic               reset,
   phy_tx_serializer_if.slave tx_if,
   output logic               serial_data_0,
   output logic               serial_data_1,
   output logic               tx_active,
   output logic               data_frame
);

   // Two comma slots make one training frame, so training lasts half as many
   // frames as there are comma slots.
   localparam logic [7:0] HALF_FRAMES = 8'(N_BC_INIT / 2);

   typedef enum logic [1:0] {
      START  = 2'd0,
      INIT   = 2'd1,
      ACTIVE = 2'd2
   } tx_state_t;

   tx_state_t   state_q;
   tx_state_t   state_d;

   logic [2:0]  bit_cnt;
   logic        slot;
   logic [15:0] shift_0;
   logic [15:0] shift_1;
   logic [31:0] hold_word;
   logic        hold_full;
   logic [7:0]  frame_cnt;

   logic        frame_end;
   logic        reload;
   logic        load_data;
   logic        accept;

   assign frame_end = (bit_cnt == 3'd7) && slot;

   // The holding register is the only buffer, so the producer may hand over a
   // word whenever it is empty. Because ready_out is low while a word is held,
   // an accept can never coincide with the reload that empties the register.
   assign tx_if.ready_out = ~hold_full;
   assign accept          = tx_if.valid_in && ~hold_full;

   assign serial_data_0 = shift_0[15];
   assign serial_data_1 = shift_1[15];
   assign tx_active     = (state_q == ACTIVE);

   // Next-state and reload decision. START loads the first comma frame on the
   // very first edge out of reset. INIT keeps sending commas until enough
   // training frames have gone out; the frame_end edge that leaves INIT is
   // already treated as an ACTIVE reload, so a word held during training goes
   // out in the very first frame after training. ACTIVE reloads at every frame
   // boundary, with the held word if there is one, otherwise with idle commas.
   always_comb begin
      state_d   = state_q;
      reload    = 1'b0;
      load_data = 1'b0;
      case (state_q)
         START: begin
            reload  = 1'b1;
            state_d = INIT;
         end
         INIT: begin
            if (frame_end) begin
               reload = 1'b1;
               if (frame_cnt == HALF_FRAMES) begin
                  state_d   = ACTIVE;
                  load_data = hold_full;
               end
            end
         end
         ACTIVE: begin
            if (frame_end) begin
               reload    = 1'b1;
               load_data = hold_full;
            end
         end
         default: begin
            state_d = START;
         end
      endcase
   end

   // State register, framing counters, lane shift registers and the holding
   // register. A reset at any point abandons the frame in flight, empties the
   // holding register and restarts training from START. Between reloads both
   // lanes shift left once per cycle, so the MSB flop always carries the bit
   // currently on the wire.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q    <= START;
         bit_cnt    <= 3'd0;
         slot       <= 1'b0;
         shift_0    <= 16'h0000;
         shift_1    <= 16'h0000;
         hold_word  <= 32'h0000_0000;
         hold_full  <= 1'b0;
         frame_cnt  <= 8'd0;
         data_frame <= 1'b0;
      end else begin
         state_q <= state_d;

         if (reload) begin
            bit_cnt    <= 3'd0;
            slot       <= 1'b0;
            data_frame <= load_data;
            if (load_data) begin
               shift_0 <= {hold_word[31:24], hold_word[15:8]};
               shift_1 <= {hold_word[23:16], hold_word[7:0]};
            end else begin
               shift_0 <= {COMMA, COMMA};
               shift_1 <= {COMMA, COMMA};
            end
            if (state_q != ACTIVE) begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               slot <= ~slot;
            end
            shift_0 <= {shift_0[14:0], 1'b0};
            shift_1 <= {shift_1[14:0], 1'b0};
         end

         if (load_data) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold_word <= tx_if.data_in;
            hold_full <= 1'b1;
         end
      end
   end

endmodule
